// File: rtl/rom_row_streamer.sv
// Streams a contiguous range of wide coefficient-ROM rows as one signed element per cycle,
// double-buffering rows so that a consumer holding ready high sees no bubble at row boundaries.
module rom_row_streamer #(
   parameter  int unsigned ROW_W  = 1024,
   parameter  int unsigned ELEM_W = 16,
   parameter  int unsigned ADDR_W = 8,
   localparam int unsigned NELEM  = ROW_W / ELEM_W,
   localparam int unsigned COL_W  = $clog2(NELEM),
   localparam int unsigned CNT_W  = ADDR_W + 1
) (
   input  logic              clk1,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  num_rows,
   input  logic [ROW_W-1:0]  rom_data,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [ELEM_W-1:0] elem_data,
   output logic              elem_valid,
   input  logic              elem_ready,
   output logic [ADDR_W-1:0] elem_row,
   output logic [COL_W-1:0]  elem_col,
   output logic              elem_last,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, PRIME, STREAM, DRAIN} state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  rows_q;
   logic [CNT_W-1:0]  fetch_left_q;
   logic              iss_q;
   logic              rdy_q;
   logic [ROW_W-1:0]  act_q;
   logic [ROW_W-1:0]  sh_q;
   logic              act_vld_q;
   logic              sh_vld_q;
   logic [ADDR_W-1:0] rom_addr_q;
   logic [ELEM_W-1:0] elem_data_q;
   logic [ADDR_W-1:0] elem_row_q;
   logic [COL_W-1:0]  elem_col_q;
   logic              elem_valid_q;
   logic              elem_last_q;
   logic              busy_q;
   logic              done_q;

   logic              streaming;
   logic              accept;
   logic              row_end;
   logic              last_accept;
   logic              issue;
   logic [ROW_W-1:0]  act_d;
   logic [ROW_W-1:0]  sh_d;
   logic              act_vld_d;
   logic              sh_vld_d;
   logic [COL_W-1:0]  col_d;
   logic [ADDR_W-1:0] row_d;
   logic [ELEM_W-1:0] data_d;
   logic              last_d;

   assign streaming   = (state_q == STREAM) || (state_q == DRAIN);
   assign accept      = elem_valid_q & elem_ready;
   assign row_end     = accept && (elem_col_q == COL_W'(NELEM - 1));
   assign last_accept = accept & elem_last_q;

   // Retire or swap the active row at its last column, then land any returning ROM row.
   always_comb begin
      act_d     = act_q;
      act_vld_d = act_vld_q;
      sh_d      = sh_q;
      sh_vld_d  = sh_vld_q;
      col_d     = elem_col_q;
      row_d     = elem_row_q;
      if (accept) begin
         col_d = elem_col_q + COL_W'(1);
      end
      if (row_end) begin
         col_d = '0;
         row_d = elem_row_q + ADDR_W'(1);
         if (sh_vld_q) begin
            act_d    = sh_q;
            sh_vld_d = 1'b0;
         end else begin
            act_vld_d = 1'b0;
         end
      end
      if (rdy_q) begin
         if (!act_vld_d) begin
            act_d     = rom_data;
            act_vld_d = 1'b1;
         end else begin
            sh_d     = rom_data;
            sh_vld_d = 1'b1;
         end
      end
   end

   // Column 0 is the most significant element of the row.
   always_comb begin
      data_d = '0;
      for (int unsigned i = 0; i < NELEM; i++) begin
         if (col_d == COL_W'(i)) begin
            data_d = act_d[ROW_W-1-ELEM_W*i -: ELEM_W];
         end
      end
   end

   assign last_d = act_vld_d && (col_d == COL_W'(NELEM - 1)) &&
                   (CNT_W'(row_d) == rows_q - CNT_W'(1));

   // One fetch in flight at a time, and only when a buffer slot will be free for it.
   assign issue = streaming && (fetch_left_q != '0) && !iss_q && !(act_vld_d && sh_vld_d);

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rows_q       <= '0;
         fetch_left_q <= '0;
         iss_q        <= 1'b0;
         rdy_q        <= 1'b0;
         act_q        <= '0;
         sh_q         <= '0;
         act_vld_q    <= 1'b0;
         sh_vld_q     <= 1'b0;
         rom_addr_q   <= '0;
         elem_data_q  <= '0;
         elem_row_q   <= '0;
         elem_col_q   <= '0;
         elem_valid_q <= 1'b0;
         elem_last_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (num_rows == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     rows_q       <= num_rows;
                     fetch_left_q <= num_rows - CNT_W'(1);
                     rom_addr_q   <= base_addr;
                     iss_q        <= 1'b1;
                     busy_q       <= 1'b1;
                     state_q      <= PRIME;
                  end
               end
            end
            PRIME: begin
               iss_q   <= 1'b0;
               rdy_q   <= iss_q;
               state_q <= STREAM;
            end
            STREAM, DRAIN: begin
               if (last_accept) begin
                  state_q      <= IDLE;
                  busy_q       <= 1'b0;
                  done_q       <= 1'b1;
                  iss_q        <= 1'b0;
                  rdy_q        <= 1'b0;
                  act_vld_q    <= 1'b0;
                  sh_vld_q     <= 1'b0;
                  elem_valid_q <= 1'b0;
                  elem_last_q  <= 1'b0;
                  elem_data_q  <= '0;
                  elem_col_q   <= '0;
                  elem_row_q   <= '0;
               end else begin
                  act_q        <= act_d;
                  sh_q         <= sh_d;
                  act_vld_q    <= act_vld_d;
                  sh_vld_q     <= sh_vld_d;
                  elem_valid_q <= act_vld_d;
                  elem_data_q  <= data_d;
                  elem_col_q   <= col_d;
                  elem_row_q   <= row_d;
                  elem_last_q  <= last_d;
                  rdy_q        <= iss_q;
                  iss_q        <= issue;
                  if (issue) begin
                     rom_addr_q   <= rom_addr_q + ADDR_W'(1);
                     fetch_left_q <= fetch_left_q - CNT_W'(1);
                  end
                  state_q <= ((fetch_left_q == '0) && !sh_vld_d) ? DRAIN : STREAM;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rom_addr   = rom_addr_q;
   assign elem_data  = elem_data_q;
   assign elem_valid = elem_valid_q;
   assign elem_row   = elem_row_q;
   assign elem_col   = elem_col_q;
   assign elem_last  = elem_last_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_rom_row_streamer.sv
// Directed bench for rom_row_streamer: synchronous ROM model, accepted-element log, per-scenario checks.
`timescale 1ns/1ps
module tb_rom_row_streamer;

   logic          clk1 = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic [7:0]    base_addr = '0;
   logic [8:0]    num_rows = '0;
   logic [1023:0] rom_data;
   logic [7:0]    rom_addr;
   logic [15:0]   elem_data;
   logic          elem_valid;
   logic          elem_ready = 1'b0;
   logic [7:0]    elem_row;
   logic [5:0]    elem_col;
   logic          elem_last;
   logic          busy;
   logic          done;

   rom_row_streamer dut (
      .clk1      (clk1),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .num_rows  (num_rows),
      .rom_data  (rom_data),
      .rom_addr  (rom_addr),
      .elem_data (elem_data),
      .elem_valid(elem_valid),
      .elem_ready(elem_ready),
      .elem_row  (elem_row),
      .elem_col  (elem_col),
      .elem_last (elem_last),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk1 = ~clk1;

   // ROM content: row r, col c holds {r, c}.
   logic [1023:0] mem [256];
   always @(posedge clk1) rom_data <= mem[rom_addr];

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] q_data[$];
   logic [7:0]  q_row[$];
   logic [5:0]  q_col[$];
   logic        q_last[$];
   int          q_edge[$];
   logic [7:0]  q_addr[$];
   int first_valid, done_at, hold_viol, gaps, busy_cnt, done_after;
   bit timed_out;

   task automatic init_mem();
      for (int r = 0; r < 256; r++)
         for (int c = 0; c < 64; c++)
            mem[r][1023-16*c -: 16] = {8'(r), 8'(c)};
   endtask

   function automatic logic [15:0] exp_data(input logic [7:0] b, input int i);
      logic [7:0] r;
      r = b + 8'(i / 64);
      return {r, 8'(i % 64)};
   endfunction

   function automatic int seq_errors(input logic [7:0] b, input int n);
      int e = 0;
      for (int i = 0; i < q_data.size(); i++)
         if (q_data[i] !== exp_data(b, i) || q_col[i] !== 6'(i % 64) ||
             q_row[i] !== 8'(i / 64) || q_last[i] !== (i == 64*n-1)) e++;
      return e;
   endfunction

   function automatic int edge_errors();
      int e = 0;
      for (int i = 0; i < q_edge.size(); i++)
         if (q_edge[i] != 3 + i) e++;
      return e;
   endfunction

   // Sample k is taken at the negedge after edge k; edge 0 samples start.
   task automatic run_xfer(input logic [7:0] b, input logic [8:0] n, input int rmode,
                           input int budget, input int inj_k);
      int k;
      bit hold;
      logic [15:0] hd; logic [7:0] hr; logic [5:0] hc; logic hl;
      q_data.delete(); q_row.delete(); q_col.delete(); q_last.delete();
      q_edge.delete(); q_addr.delete();
      first_valid = -1; done_at = -1; hold_viol = 0; gaps = 0; busy_cnt = 0; timed_out = 0;
      hd = '0; hr = '0; hc = '0; hl = 1'b0;
      @(negedge clk1);
      start = 1'b1; base_addr = b; num_rows = n; elem_ready = 1'b0;
      @(negedge clk1);
      start = 1'b0;
      hold = 1'b0;
      k = 0;
      forever begin
         if (hold && (!elem_valid || elem_data !== hd || elem_col !== hc ||
                      elem_row !== hr || elem_last !== hl)) hold_viol++;
         if (elem_valid && first_valid < 0) first_valid = k;
         if (first_valid >= 0 && !elem_valid && !done) gaps++;
         if (busy) busy_cnt++;
         if (q_addr.size() == 0 || q_addr[$] !== rom_addr) q_addr.push_back(rom_addr);
         if (done) begin done_at = k; break; end
         if (k >= budget) begin timed_out = 1'b1; break; end
         if (k == inj_k) begin start = 1'b1; base_addr = 8'd200; num_rows = 9'd1; end
         else start = 1'b0;
         elem_ready = (rmode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
         hold = elem_valid && !elem_ready;
         hd = elem_data; hr = elem_row; hc = elem_col; hl = elem_last;
         if (elem_valid && elem_ready) begin
            q_data.push_back(elem_data); q_row.push_back(elem_row);
            q_col.push_back(elem_col); q_last.push_back(elem_last);
            q_edge.push_back(k + 1);
         end
         @(negedge clk1);
         k++;
      end
      start = 1'b0;
      elem_ready = 1'b0;
      @(negedge clk1);
      done_after = int'(done);
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk1);
      n_cmp++;
      if (rom_addr !== 8'd0) begin n_bad++; $display("FAIL reset_rom_addr: got %0h want 0", rom_addr); end
      n_cmp++;
      if ({elem_valid, elem_last, busy, done} !== 4'b0000) begin
         n_bad++; $display("FAIL reset_flags: got %b want 0000", {elem_valid, elem_last, busy, done});
      end
      n_cmp++;
      if ({elem_data, elem_row, elem_col} !== 30'd0) begin
         n_bad++; $display("FAIL reset_elem: got %0h/%0h/%0h want 0", elem_data, elem_row, elem_col);
      end
      rst_n = 1'b1;
      @(negedge clk1);
   endtask

   task automatic test_single_row();
      int e;
      run_xfer(8'd0, 9'd1, 0, 300, -1);
      n_cmp++;
      if (timed_out) begin n_bad++; $display("FAIL single_timeout: no done within budget"); end
      n_cmp++;
      if (first_valid !== 2) begin n_bad++; $display("FAIL single_first_valid: got %0d want 2", first_valid); end
      n_cmp++;
      if (q_data.size() !== 64) begin n_bad++; $display("FAIL single_count: got %0d want 64", q_data.size()); end
      e = seq_errors(8'd0, 1);
      n_cmp++;
      if (e !== 0) begin n_bad++; $display("FAIL single_seq: got %0d bad elements want 0", e); end
      e = edge_errors();
      n_cmp++;
      if (e !== 0) begin n_bad++; $display("FAIL single_accept_edges: got %0d off-time accepts want 0", e); end
      n_cmp++;
      if (done_at !== 66) begin n_bad++; $display("FAIL single_done_at: got %0d want 66", done_at); end
      n_cmp++;
      if (busy_cnt !== 66) begin n_bad++; $display("FAIL single_busy_cycles: got %0d want 66", busy_cnt); end
      n_cmp++;
      if (done_after !== 0) begin n_bad++; $display("FAIL single_done_width: done still %0d a cycle later", done_after); end
   endtask

   task automatic test_long_run();
      int e;
      run_xfer(8'd128, 9'd128, 0, 9000, -1);
      n_cmp++;
      if (timed_out) begin n_bad++; $display("FAIL long_timeout: no done within budget"); end
      n_cmp++;
      if (q_data.size() !== 8192) begin n_bad++; $display("FAIL long_count: got %0d want 8192", q_data.size()); end
      e = seq_errors(8'd128, 128);
      n_cmp++;
      if (e !== 0) begin n_bad++; $display("FAIL long_seq: got %0d bad elements want 0", e); end
      e = edge_errors();
      n_cmp++;
      if (e !== 0 || gaps !== 0) begin
         n_bad++; $display("FAIL long_no_bubble: got %0d late accepts, %0d gaps want 0", e, gaps);
      end
      n_cmp++;
      if (done_at !== 8194) begin n_bad++; $display("FAIL long_done_at: got %0d want 8194", done_at); end
      e = 0;
      for (int i = 0; i < q_addr.size(); i++) if (q_addr[i] !== 8'(128 + i)) e++;
      n_cmp++;
      if (q_addr.size() !== 128 || e !== 0) begin
         n_bad++; $display("FAIL long_rom_addr: got %0d addrs, %0d wrong want 128, 0", q_addr.size(), e);
      end
   endtask

   task automatic test_wrap();
      int e;
      logic [7:0] want [4];
      want[0] = 8'd254; want[1] = 8'd255; want[2] = 8'd0; want[3] = 8'd1;
      run_xfer(8'd254, 9'd4, 0, 600, -1);
      e = 0;
      for (int i = 0; i < q_addr.size() && i < 4; i++) if (q_addr[i] !== want[i]) e++;
      n_cmp++;
      if (q_addr.size() !== 4 || e !== 0) begin
         n_bad++; $display("FAIL wrap_rom_addr: got %0d addrs, %0d wrong want 4, 0", q_addr.size(), e);
      end
      e = seq_errors(8'd254, 4);
      n_cmp++;
      if (q_data.size() !== 256 || e !== 0) begin
         n_bad++; $display("FAIL wrap_seq: got %0d elements, %0d bad want 256, 0", q_data.size(), e);
      end
      n_cmp++;
      if (done_at !== 258) begin n_bad++; $display("FAIL wrap_done_at: got %0d want 258", done_at); end
   endtask

   task automatic test_stall();
      int e;
      run_xfer(8'd10, 9'd3, 1, 2000, -1);
      n_cmp++;
      if (timed_out) begin n_bad++; $display("FAIL stall_timeout: no done within budget"); end
      n_cmp++;
      if (q_data.size() !== 192) begin n_bad++; $display("FAIL stall_count: got %0d want 192", q_data.size()); end
      e = seq_errors(8'd10, 3);
      n_cmp++;
      if (e !== 0) begin n_bad++; $display("FAIL stall_seq: got %0d bad elements want 0", e); end
      n_cmp++;
      if (hold_viol !== 0) begin n_bad++; $display("FAIL stall_hold: got %0d unstable stalls want 0", hold_viol); end
   endtask

   task automatic test_zero_rows();
      logic [7:0] addr_before;
      int noisy;
      addr_before = rom_addr;
      run_xfer(8'd77, 9'd0, 0, 20, -1);
      n_cmp++;
      if (done_at !== 0) begin n_bad++; $display("FAIL zero_done_at: got %0d want 0", done_at); end
      n_cmp++;
      if (busy_cnt !== 0 || first_valid !== -1) begin
         n_bad++; $display("FAIL zero_quiet: got busy %0d cycles, first valid %0d want 0, -1", busy_cnt, first_valid);
      end
      noisy = 0;
      repeat (6) begin
         @(negedge clk1);
         if (elem_valid || busy || done) noisy++;
      end
      n_cmp++;
      if (noisy !== 0) begin n_bad++; $display("FAIL zero_after: got %0d active cycles want 0", noisy); end
      n_cmp++;
      if (rom_addr !== addr_before) begin
         n_bad++; $display("FAIL zero_rom_addr: got %0d want %0d", rom_addr, addr_before);
      end
   endtask

   task automatic test_busy_start();
      int e;
      run_xfer(8'd50, 9'd2, 0, 600, 5);
      e = seq_errors(8'd50, 2);
      n_cmp++;
      if (q_data.size() !== 128 || e !== 0) begin
         n_bad++; $display("FAIL busy_start_seq: got %0d elements, %0d bad want 128, 0", q_data.size(), e);
      end
      n_cmp++;
      if (done_at !== 130) begin n_bad++; $display("FAIL busy_start_done_at: got %0d want 130", done_at); end
      n_cmp++;
      if (q_addr.size() !== 2 || q_addr[0] !== 8'd50 || q_addr[$] !== 8'd51) begin
         n_bad++; $display("FAIL busy_start_rom_addr: got %0d addrs last %0d want 2 ending 51", q_addr.size(), q_addr[$]);
      end
      repeat (4) @(negedge clk1);
      n_cmp++;
      if (busy !== 1'b0 || elem_valid !== 1'b0) begin
         n_bad++; $display("FAIL busy_start_idle: got busy %b valid %b want 0 0", busy, elem_valid);
      end
   endtask

   task automatic test_reset_mid();
      bit found;
      int dcnt, e;
      @(negedge clk1);
      start = 1'b1; base_addr = 8'd0; num_rows = 9'd5; elem_ready = 1'b1;
      @(negedge clk1);
      start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 600; k++) begin
         if (elem_valid && elem_row == 8'd3 && elem_col == 6'd20) begin found = 1'b1; break; end
         @(negedge clk1);
      end
      n_cmp++;
      if (!found) begin n_bad++; $display("FAIL rst_mid_reach: row 3 col 20 not reached"); end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({rom_addr, elem_data, elem_row, elem_col, elem_valid, elem_last, busy, done} !== 42'd0) begin
         n_bad++; $display("FAIL rst_mid_outputs: got addr %0d data %0h row %0d col %0d flags %b want all 0",
                           rom_addr, elem_data, elem_row, elem_col, {elem_valid, elem_last, busy, done});
      end
      elem_ready = 1'b0;
      @(negedge clk1);
      rst_n = 1'b1;
      dcnt = 0;
      repeat (10) begin
         @(negedge clk1);
         if (done) dcnt++;
      end
      n_cmp++;
      if (dcnt !== 0) begin n_bad++; $display("FAIL rst_mid_no_done: got %0d done cycles want 0", dcnt); end
      run_xfer(8'd3, 9'd2, 0, 600, -1);
      n_cmp++;
      if (first_valid !== 2) begin n_bad++; $display("FAIL rst_mid_restart_valid: got %0d want 2", first_valid); end
      e = seq_errors(8'd3, 2);
      n_cmp++;
      if (q_data.size() !== 128 || e !== 0) begin
         n_bad++; $display("FAIL rst_mid_restart_seq: got %0d elements, %0d bad want 128, 0", q_data.size(), e);
      end
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      init_mem();
      test_reset();
      test_single_row();
      test_long_run();
      test_wrap();
      test_stall();
      test_zero_rows();
      test_busy_start();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rom_row_streamer.md
Name: rom_row_streamer

Overview:
- Upstream feeder for the matrix-multiply datapath.
- Walks a contiguous range of the 1024-bit-wide coefficient ROM, one row per ROM address.
- Splits each row into 64 signed 16-bit elements and streams them one per cycle over a valid/ready interface.
- Double-buffers rows so that, with ready held high, there is no bubble between consecutive rows.

Parameters:
- ROW_W, 1024, ROM row width in bits.
- ELEM_W, 16, element width; ROW_W/ELEM_W = 64 elements per row.
- ADDR_W, 8, ROM address width.

Ports:
- clk1  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  8  first ROM row of the transfer.
- num_rows  in  9  rows to stream, 0..256.
- rom_data  in  1024  ROM read data; 1-cycle latency from rom_addr.
- rom_addr  out  8  registered ROM address.
- elem_data  out  16  current element.
- elem_valid  out  1  elem_data valid.
- elem_ready  in  1  consumer accepts when valid & ready.
- elem_row  out  8  row offset of the current element from base_addr.
- elem_col  out  6  element index within the row.
- elem_last  out  1  high with the final element of the transfer.
- busy  out  1  high from the start acceptance edge until the done pulse.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, both row buffers invalid. Reset mid-transfer abandons it; no done pulse.
- ROM timing: rom_data during cycle k+1 reflects the rom_addr registered at edge k.
- Element order: col c = row[ROW_W-1-16c -: 16], i.e. MSB-first; col 0 is bits [1023:1008].
- States:
  - IDLE: on start=1 with num_rows!=0, latch num_rows; rom_addr<=base_addr; busy<=1; go to PRIME. Start with num_rows=0 gives done=1 the next cycle, busy stays 0, no ROM access.
  - PRIME: wait one cycle for ROM latency.
  - STREAM: active buffer drives elem_*.
  - DRAIN: last row streaming, no further fetches.
- Pipelined fetch: the active buffer is captured from rom_data at the edge after PRIME.
  - First elem_valid rises at edge start+2, i.e. two clocks after start is sampled.
  - After each capture, rom_addr increments (mod 256, wrap 255->0 is legal) if rows remain to fetch.
  - The shadow buffer captures the next row one cycle later.
  - At most one fetch is outstanding; no fetch is issued while the shadow buffer is full.
- Handshake:
  - elem_data, elem_row, elem_col and elem_last hold stable while elem_valid=1 and elem_ready=0.
  - elem_col increments on each accept.
  - Accepting col 63 with the shadow buffer valid swaps shadow->active in the same edge: elem_valid stays 1, elem_col<=0, elem_row increments.
  - If the shadow buffer is not yet valid, elem_valid drops until it fills.
- elem_last=1 only on col 63 of row num_rows-1.
- Completion: accepting elem_last gives elem_valid<=0, state IDLE, done=1 for exactly one cycle, busy<=0 on the same edge.
- start while busy is ignored; base_addr and num_rows are sampled only at acceptance.
- Total accepted elements = 64*num_rows. Minimum transfer time with ready always 1 is 64*num_rows+2 cycles to the last accept.

Test Plan:
- base=0, num_rows=1, row0 = 0x0000_0001_..._003F (col c = c), ready=1 -> elem_valid at cycle 2; cols 0..63 carry data 0..63 on consecutive cycles; elem_last on col 63; done pulse one cycle later.
- base=128, num_rows=128, ready=1 -> 8192 elements with no gap between rows; rom_addr visits 128..255; elem_row reaches 127; done after cycle 8194.
- base=254, num_rows=4 -> rom_addr sequence 254, 255, 0, 1; elem_row 0..3; data matches ROM rows 254, 255, 0, 1.
- ready toggled 1,0,0,1 pattern -> elem_data and elem_col held during stalls; no element lost or duplicated; scoreboard count = 64*num_rows.
- num_rows=0 -> done=1 one cycle after start; elem_valid never rises; rom_addr unchanged. Second start issued while busy -> ignored.
- rst_n pulsed low mid-row (col 20, row 3) -> all outputs 0 immediately; a fresh start afterwards streams correctly from col 0.
